// File: rtl/rollover_monitor_pkg.sv
// Shared types and constants for the rollover monitor: event kind, event record
// layout and drop-counter width.
package rollover_monitor_pkg;

    localparam int DROP_CNT_W = 8;
    localparam int EVT_TS_W   = 16;
    localparam int TOTAL_W    = 16;

    typedef enum logic {
        EVT_UP = 1'b0,
        EVT_DN = 1'b1
    } evt_kind_e;

    typedef struct packed {
        logic [EVT_TS_W-1:0] ts;
        evt_kind_e           kind;
        logic                load;
    } evt_rec_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rollover_monitor_if.sv
// Valid/ready event stream carrying one detected wrap event per transfer.
interface rollover_monitor_if #(
    parameter int TS_W = 16
) ();

    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;
    logic            evt_kind;
    logic            evt_load;

    modport master (
        output evt_valid,
        output evt_ts,
        output evt_kind,
        output evt_load,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ts,
        input  evt_kind,
        input  evt_load,
        output evt_ready
    );

endinterface

// File: rtl/rollover_fifo.sv
// Single-clock event FIFO; a push into a full FIFO is only accepted when a pop
// retires the head on the same edge.
module rollover_fifo #(
    parameter  int DW    = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: nothing is read out while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rollover_monitor.sv
// Watches an upstream counter for up/down wraps, timestamps them and queues them
// on a valid/ready stream. Optional macro ROLLOVER_MONITOR_TOTAL_EN adds evt_total.
module rollover_monitor
    import rollover_monitor_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int TS_W  = 16,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIDTH-1:0]      count,
    input  logic                  rollover,
    input  logic                  down,
    input  logic                  load_en,
    input  logic                  clr,
    rollover_monitor_if.master    evt,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef ROLLOVER_MONITOR_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0]    evt_total
`endif
);

    logic            rollover_q;
    logic            zero_q;
    logic            load_en_q;
    logic [TS_W-1:0] ts;

    logic            count_zero;
    logic            det_up;
    logic            det_dn;
    logic            det;
    logic            push;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    evt_kind_e       wr_kind;
    logic [TS_W+1:0] wdata;
    logic [TS_W+1:0] rdata;

    assign count_zero = (count == '0);

    // All-ones and zero are exclusive, so the two detectors never fire together.
    assign det_up  = rollover && !rollover_q;
    assign det_dn  = count_zero && !zero_q && down;
    assign det     = det_up || det_dn;
    assign wr_kind = det_dn ? EVT_DN : EVT_UP;

    assign push  = det && !clr;
    assign pop   = !empty && evt.evt_ready && !clr;
    assign drop  = push && full && !pop;
    assign wdata = {ts, wr_kind, load_en_q};

    // History keeps tracking through clr; zero_q starts high so the upstream
    // reset value of 0 does not look like a fresh down-wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rollover_q <= 1'b0;
            zero_q     <= 1'b1;
            load_en_q  <= 1'b0;
        end else begin
            rollover_q <= rollover;
            zero_q     <= count_zero;
            load_en_q  <= load_en;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts <= '0;
        end else if (clr) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= sat_inc_drop(drop_cnt);
            overflow <= 1'b1;
        end
    end

`ifdef ROLLOVER_MONITOR_TOTAL_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_total <= '0;
        end else if (clr) begin
            evt_total <= '0;
        end else if (push && (evt_total != '1)) begin
            evt_total <= evt_total + 1'b1;
        end
    end
`endif

    rollover_fifo #(
        .DW    (TS_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Fields are forced to zero while empty so reset clears them immediately.
    assign evt.evt_valid = !empty;
    assign evt.evt_ts    = empty ? '0 : rdata[TS_W+1:2];
    assign evt.evt_kind  = !empty && rdata[1];
    assign evt.evt_load  = !empty && rdata[0];

endmodule

// File: tb/tb_rollover_monitor.sv
// Randomised and directed bench for rollover_monitor with a queue-based
// reference model and a decoupled scoreboard monitor.
`timescale 1ns/1ps
module tb_rollover_monitor;
    import rollover_monitor_pkg::*;

    localparam int WIDTH = 4;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic [3:0] count    = 4'h0;
    logic       rollover = 1'b0;
    logic       down     = 1'b0;
    logic       load_en  = 1'b0;
    logic       clr      = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;
`ifdef ROLLOVER_MONITOR_TOTAL_EN
    logic [15:0] evt_total;
`endif

    rollover_monitor_if #(.TS_W(TS_W)) eif ();

    rollover_monitor #(
        .WIDTH (WIDTH),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .count      (count),
        .rollover   (rollover),
        .down       (down),
        .load_en    (load_en),
        .clr        (clr),
        .evt        (eif),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
`ifdef ROLLOVER_MONITOR_TOTAL_EN
        ,
        .evt_total  (evt_total)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events in flight, occupancy and counters.
    evt_rec_t sb_q[$];
    int  m_level, m_drops, m_ts, m_total;
    bit  m_ovf, m_prev_roll, m_prev_zero, m_prev_load;
    bit  m_up, m_dn, m_pop;
    evt_rec_t m_rec;

    always @(negedge clk) begin
        #3;
        if (!rstn) begin
            m_level = 0; m_drops = 0; m_ts = 0; m_total = 0; m_ovf = 0;
            m_prev_roll = 0; m_prev_zero = 1; m_prev_load = 0;
            sb_q.delete();
        end else begin
            check("fifo_level", int'(fifo_level), m_level);
            check("evt_valid", int'(eif.evt_valid), int'(m_level > 0));
            check("drop_cnt", int'(drop_cnt), m_drops);
            check("overflow", int'(overflow), int'(m_ovf));
`ifdef ROLLOVER_MONITOR_TOTAL_EN
            check("evt_total", int'(evt_total), m_total);
`endif
            m_up  = rollover && !m_prev_roll;
            m_dn  = (count == 4'h0) && !m_prev_zero && down;
            m_pop = (m_level > 0) && eif.evt_ready && !clr;
            if (clr) begin
                m_level = 0; m_drops = 0; m_ovf = 0; m_ts = 0; m_total = 0;
                sb_q.delete();
            end else begin
                if (m_pop) m_level--;
                if (m_up || m_dn) begin
                    if (m_total < 65535) m_total++;
                    if (m_level < DEPTH) begin
                        m_level++;
                        m_rec.ts   = 16'(m_ts);
                        m_rec.kind = m_dn ? EVT_DN : EVT_UP;
                        m_rec.load = m_prev_load;
                        sb_q.push_back(m_rec);
                    end else begin
                        if (m_drops < 255) m_drops++;
                        m_ovf = 1;
                    end
                end
                m_ts = (m_ts + 1) % 65536;
            end
            m_prev_roll = rollover;
            m_prev_zero = (count == 4'h0);
            m_prev_load = load_en;
        end
    end

    // Scoreboard monitor: pops on every handshake the DUT presents.
    int        n_popped = 0;
    int        last_ts, last_kind, last_load;
    bit        held = 0;
    logic [15:0] h_ts;
    logic      h_kind, h_load;
    evt_rec_t  exp_rec;

    always @(negedge clk) begin
        #3;
        if (!rstn) begin
            held = 0;
        end else begin
            if (held && eif.evt_valid) begin
                check("hold_ts", int'(eif.evt_ts), int'(h_ts));
                check("hold_kind", int'(eif.evt_kind), int'(h_kind));
                check("hold_load", int'(eif.evt_load), int'(h_load));
            end
            if (eif.evt_valid && eif.evt_ready && !clr) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL evt_unexpected: got ts %0d expected no event", eif.evt_ts);
                end else begin
                    exp_rec = sb_q.pop_front();
                    check("evt_ts", int'(eif.evt_ts), int'(exp_rec.ts));
                    check("evt_kind", int'(eif.evt_kind), int'(exp_rec.kind));
                    check("evt_load", int'(eif.evt_load), int'(exp_rec.load));
                    n_popped++;
                    last_ts = int'(eif.evt_ts);
                    last_kind = int'(eif.evt_kind);
                    last_load = int'(eif.evt_load);
                end
            end
            held = eif.evt_valid && !eif.evt_ready && !clr;
            h_ts = eif.evt_ts; h_kind = eif.evt_kind; h_load = eif.evt_load;
        end
    end

    task automatic cyc(input logic [3:0] c, input logic d, input logic le,
                       input logic rdy, input logic cl);
        @(negedge clk);
        count = c; rollover = (c == 4'hF); down = d;
        load_en = le; eif.evt_ready = rdy; clr = cl;
    endtask

    task automatic do_reset(input logic [3:0] c, input logic d);
        @(negedge clk);
        rstn = 1'b0;
        count = c; rollover = (c == 4'hF); down = d;
        load_en = 1'b0; clr = 1'b0; eif.evt_ready = 1'b1;
        #1;
        check("rst_valid", int'(eif.evt_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_drop", int'(drop_cnt), 0);
        check("rst_ts", int'(eif.evt_ts), 0);
        check("rst_kind", int'(eif.evt_kind), 0);
        check("rst_load", int'(eif.evt_load), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] cnt;
    logic       dir, rdy_r;
    int         p0;

    initial begin
        eif.evt_ready = 1'b1;

        // Up-count from reset: one up-wrap with ts 15.
        do_reset(4'h0, 1'b0);
        p0 = n_popped;
        for (int k = 1; k <= 20; k++) cyc(4'(k), 1'b0, 1'b0, 1'b1, 1'b0);
        check("up_count_events", n_popped - p0, 1);
        check("up_ts", last_ts, 15);
        check("up_kind", last_kind, 0);
        check("up_load", last_load, 0);

        // Down direction at reset release: no event; then load 3 and count to 0.
        do_reset(4'h0, 1'b1);
        p0 = n_popped;
        cyc(4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("no_evt_at_release", n_popped - p0, 0);
        cyc(4'h3, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4'h2, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("dn_events", n_popped - p0, 1);
        check("dn_kind", last_kind, 1);
        check("dn_load", last_load, 0);

        // Load of 0xF from 0x5 produces an up-wrap flagged as load-caused.
        cyc(4'h5, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("load_kind", last_kind, 0);
        check("load_flag", last_load, 1);

        // Six wraps with the sink stalled: four stored, two dropped.
        for (int k = 0; k < 6; k++) begin
            cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_level", int'(fifo_level), 4);
        check("stall_drop", int'(drop_cnt), 2);
        check("stall_ovf", int'(overflow), 1);
        p0 = n_popped;
        for (int k = 0; k < 8; k++) cyc(4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_events", n_popped - p0, 4);
        check("drain_level", int'(fifo_level), 0);

        // Full FIFO with a wrap on the same edge as a pop: no drop.
        for (int k = 0; k < 4; k++) begin
            cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pushpop_level", int'(fifo_level), 4);
        check("pushpop_drop", int'(drop_cnt), 2);

        // Clear with three pending and a wrap in the clear cycle.
        cyc(4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_clr_level", int'(fifo_level), 3);
        cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_level", int'(fifo_level), 0);
        check("clr_valid", int'(eif.evt_valid), 0);
        check("clr_drop", int'(drop_cnt), 0);
        check("clr_ovf", int'(overflow), 0);
        cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_ts_restart", last_ts, 1);

        // Reset while draining discards everything pending.
        for (int k = 0; k < 3; k++) begin
            cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset(4'h0, 1'b0);
        p0 = n_popped;
        for (int k = 0; k < 6; k++) cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_events", n_popped - p0, 0);

        // Long stall: drop counter saturates.
        for (int k = 0; k < 270; k++) begin
            cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_saturate", int'(drop_cnt), 255);
        cyc(4'hE, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomised upstream counter with loads, direction flips, stalls, clears.
        cnt = 4'h0; dir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic le, cl;
            le = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            if ((i / 200) % 2 == 0) rdy_r = ($urandom_range(0, 3) != 0);
            else                    rdy_r = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 149) == 0);
            cyc(cnt, dir, le, rdy_r, cl);
            if (le) cnt = 4'($urandom);
            else    cnt = dir ? cnt - 4'h1 : cnt + 4'h1;
        end

        for (int k = 0; k < 10; k++) cyc(cnt, 1'b0, 1'b0, 1'b1, 1'b0);
        check("final_sb_empty", sb_q.size(), 0);
        check("final_level", int'(fifo_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rollover_monitor.md
ROLLOVER_MONITOR -- requirements
Module: rollover_monitor

Interface
REQ-001 Parameters SHALL be: WIDTH, 4, counter width; TS_W, 16, timestamp width; DEPTH, 4, event FIFO entries (power of two, >=2).
REQ-002 clk  in  1  clock; all state on posedge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 count  in  WIDTH  upstream counter value; rollover  in  1  upstream all-ones flag.
REQ-005 down  in  1  upstream direction; load_en  in  1  upstream load strobe.
REQ-006 clr  in  1  synchronous clear of FIFO, timestamp and error state.
REQ-007 evt_valid  out  1; evt_ready  in  1: valid/ready event output handshake.
REQ-008 evt_ts  out  TS_W  event timestamp; evt_kind  out  1  0=up-wrap, 1=down-wrap; evt_load  out  1  event caused by a load.
REQ-009 fifo_level  out  $clog2(DEPTH+1)  occupancy; overflow  out  1  sticky drop flag; drop_cnt  out  8  dropped events.

Function
REQ-010 Up-wrap event SHALL fire at a posedge where rollover=1 and rollover_q=0 (rollover_q = rollover of previous edge).
REQ-011 Down-wrap event SHALL fire at a posedge where count==0, zero_q=0 and down=1.
REQ-012 Both events in one cycle are impossible (all-ones != zero); the block SHALL NOT need priority logic.
REQ-013 evt_load SHALL equal load_en sampled at the edge before detection (load_en_q).
REQ-014 Timestamp ts SHALL increment every edge, wrap 2^TS_W-1 -> 0, and be sampled pre-increment into the event.
REQ-015 Detected event SHALL be written at the detection edge; evt_valid SHALL be high in the following cycle when the FIFO was empty (latency 1).
REQ-016 Pop SHALL occur on any edge with evt_valid && evt_ready; output fields SHALL be stable while evt_valid && !evt_ready.
REQ-017 Events SHALL leave in detection order.
REQ-018 Full, push, no pop: event dropped, drop_cnt +1 saturating at 255, overflow set until clr/reset.
REQ-019 Full, push and pop same edge: push accepted, no drop, level unchanged.
REQ-020 Empty, push: pop impossible that edge; level becomes 1.
REQ-021 clr SHALL zero FIFO, ts, drop_cnt, overflow; an event detected in the clr cycle SHALL be discarded and not counted; clr SHALL take precedence over pop.
REQ-022 rollover_q, zero_q, load_en_q SHALL keep updating during clr.

Reset
REQ-023 rstn low SHALL immediately force evt_valid=0, fifo_level=0, overflow=0, drop_cnt=0, ts=0, evt_ts/evt_kind/evt_load=0, rollover_q=0, load_en_q=0, zero_q=1.
REQ-024 zero_q=1 at reset SHALL suppress a spurious down-wrap from the upstream reset value 0.
REQ-025 Reset asserted mid-drain SHALL discard all pending events.

Configuration
REQ-026 Macro ROLLOVER_MONITOR_TOTAL_EN defined: extra port evt_total out 16 counting every detected event (accepted + dropped), saturating at 0xFFFF, zeroed by clr/reset.
REQ-027 Macro undefined: evt_total port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package rollover_monitor_pkg SHALL hold the event record typedef (ts, kind, load), kind enum (EVT_UP, EVT_DN) and DROP_CNT_W=8.
REQ-029 FIFO storage/pointers SHALL be sub-module rollover_fifo (sync, single clock, push/pop/full/empty/level).

Verification (WIDTH=4, TS_W=16, DEPTH=4)
REQ-030 Reset release, up-count from 0, evt_ready=1 -> one event, kind=0, ts=15, evt_load=0, evt_valid high 1 cycle.
REQ-031 load 0x3 with down=1, then count down -> event kind=1, evt_load=0 when count reaches 0x0; no event at reset release.
REQ-032 load_en=1 load=0xF from count 0x5 -> event kind=0, evt_load=1.
REQ-033 evt_ready=0, 6 up-wraps -> fifo_level=4, drop_cnt=2, overflow=1; then evt_ready=1 -> 4 events, ts ascending, level 0.
REQ-034 FIFO full, wrap coincides with pop -> no drop, fifo_level stays 4, drop_cnt unchanged.
REQ-035 clr with 3 pending -> next cycle level=0, evt_valid=0, drop_cnt=0, overflow=0, ts=0; rstn low mid-drain -> all outputs 0 same time step.
